mdu_issue_ctrl: RTL and testbench

MDU_ISSUE_CTRL -- requirements
Module: mdu_issue_ctrl

---
 rtl/mdu_pkg.sv | 42 ++++
 rtl/mdu_cycle_counter.sv | 27 ++
 rtl/mdu_issue_ctrl.sv | 89 ++++++++
 tb/tb_mdu_issue_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and default latencies for the multiply/divide issue controller.
// Also holds the small helpers used to decode the E-stage class.
package mdu_pkg;

    typedef enum logic [3:0] {
        CLS_NONE  = 4'd0,
        CLS_MULT  = 4'd1,
        CLS_MULTU = 4'd2,
        CLS_DIV   = 4'd3,
        CLS_DIVU  = 4'd4,
        CLS_MFHI  = 4'd5,
        CLS_MFLO  = 4'd6,
        CLS_MTHI  = 4'd7,
        CLS_MTLO  = 4'd8
    } mdu_class_e;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;

    // Classes 9..15 fall through to "not a start class", i.e. behave as NONE.
    function automatic logic is_start_class(input logic [3:0] cls);
        return (cls == CLS_MULT) || (cls == CLS_MULTU) ||
               (cls == CLS_DIV)  || (cls == CLS_DIVU);
    endfunction

    function automatic logic is_mult_class(input logic [3:0] cls);
        return (cls == CLS_MULT) || (cls == CLS_MULTU);
    endfunction

endpackage

// File: rtl/mdu_cycle_counter.sv
// Loadable 4-bit down-counter; o_tc flags the last busy cycle (count == 1).
module mdu_cycle_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic [3:0] o_count,
    output logic       o_tc
);

    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == 4'd1);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// Issue/sequencing control for the MDU: start pulse, busy/stall, HI/LO strobes
// and a commit pulse timed by a per-operation latency.
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       E_valid,
    input  logic [3:0] E_class,
    input  logic       Req,
    input  logic       D_uses_mdu,
    output logic       mdu_start,
    output logic [2:0] mdu_op,
    output logic       hi_write,
    output logic       lo_write,
    output logic       hi_read,
    output logic       lo_read,
    output logic       busy,
    output logic       stall_D,
    output logic       commit,
    output logic [3:0] cnt,
    output logic       o_dbg_state
);

    mdu_state_e r_state;
    logic       w_idle;
    logic       w_run;
    logic       w_start;
    logic       w_tc;
    logic [3:0] w_cnt;
    logic [3:0] w_load_val;
    logic [2:0] w_op;

    assign w_idle = (r_state == ST_IDLE);
    assign w_run  = (r_state == ST_RUN);

    // Starts and MT writes are only honoured from IDLE with no pending exception.
    assign w_start    = w_idle && E_valid && is_start_class(E_class) && !Req;
    assign w_load_val = is_mult_class(E_class) ? 4'(MULT_LAT) : 4'(DIV_LAT);

    always_comb begin
        w_op = OP_MULT;
        case (E_class)
            CLS_MULTU: w_op = OP_MULTU;
            CLS_DIV:   w_op = OP_DIV;
            CLS_DIVU:  w_op = OP_DIVU;
            default:   w_op = OP_MULT;
        endcase
    end

    mdu_cycle_counter u_counter (
        .clk        (clk),
        .rst_n      (reset),
        .i_load     (w_start),
        .i_load_val (w_load_val),
        .i_dec      (w_run),
        .o_count    (w_cnt),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_start) r_state <= ST_RUN;
                ST_RUN:  if (w_tc)    r_state <= ST_IDLE;
                default:              r_state <= ST_IDLE;
            endcase
        end
    end

    // Every output is forced low while reset is asserted, even before the edge.
    assign mdu_start   = reset && w_start;
    assign mdu_op      = (reset && w_start) ? w_op : 3'd0;
    assign hi_write    = reset && E_valid && (E_class == CLS_MTHI) && w_idle && !Req;
    assign lo_write    = reset && E_valid && (E_class == CLS_MTLO) && w_idle && !Req;
    assign hi_read     = reset && E_valid && (E_class == CLS_MFHI);
    assign lo_read     = reset && E_valid && (E_class == CLS_MFLO);
    assign busy        = reset && (w_run || w_start);
    assign stall_D     = D_uses_mdu && busy;
    assign commit      = reset && w_run && w_tc;
    assign cnt         = reset ? w_cnt : 4'd0;
    assign o_dbg_state = reset && w_run;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: two instances (default latencies and 1/15) checked
// every cycle against a remaining-cycles model, plus directed scenarios.
module tb_mdu_issue_ctrl;

    localparam logic [3:0] C_NONE  = 4'd0;
    localparam logic [3:0] C_MULT  = 4'd1;
    localparam logic [3:0] C_MULTU = 4'd2;
    localparam logic [3:0] C_DIV   = 4'd3;
    localparam logic [3:0] C_DIVU  = 4'd4;
    localparam logic [3:0] C_MFHI  = 4'd5;
    localparam logic [3:0] C_MFLO  = 4'd6;
    localparam logic [3:0] C_MTHI  = 4'd7;
    localparam logic [3:0] C_MTLO  = 4'd8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       e_valid = 1'b0;
    logic [3:0] e_class = 4'd0;
    logic       req = 1'b0;
    logic       d_uses = 1'b0;

    logic       start_o  [2];
    logic [2:0] op_o     [2];
    logic       hiw_o    [2];
    logic       low_o    [2];
    logic       hir_o    [2];
    logic       lor_o    [2];
    logic       busy_o   [2];
    logic       stall_o  [2];
    logic       commit_o [2];
    logic [3:0] cnt_o    [2];
    logic       dbg_o    [2];

    int n_checks = 0;
    int n_errors = 0;
    int rem [2] = '{0, 0};

    always #5 clk = ~clk;

    mdu_issue_ctrl u_dut0 (
        .clk(clk), .reset(reset), .E_valid(e_valid), .E_class(e_class), .Req(req),
        .D_uses_mdu(d_uses), .mdu_start(start_o[0]), .mdu_op(op_o[0]),
        .hi_write(hiw_o[0]), .lo_write(low_o[0]), .hi_read(hir_o[0]), .lo_read(lor_o[0]),
        .busy(busy_o[0]), .stall_D(stall_o[0]), .commit(commit_o[0]), .cnt(cnt_o[0]),
        .o_dbg_state(dbg_o[0])
    );

    mdu_issue_ctrl #(.MULT_LAT(1), .DIV_LAT(15)) u_dut1 (
        .clk(clk), .reset(reset), .E_valid(e_valid), .E_class(e_class), .Req(req),
        .D_uses_mdu(d_uses), .mdu_start(start_o[1]), .mdu_op(op_o[1]),
        .hi_write(hiw_o[1]), .lo_write(low_o[1]), .hi_read(hir_o[1]), .lo_read(lor_o[1]),
        .busy(busy_o[1]), .stall_D(stall_o[1]), .commit(commit_o[1]), .cnt(cnt_o[1]),
        .o_dbg_state(dbg_o[1])
    );

    function automatic int lat_of(input int inst, input logic [3:0] cls);
        if (cls == C_MULT || cls == C_MULTU) return (inst == 0) ? 5 : 1;
        return (inst == 0) ? 10 : 15;
    endfunction

    function automatic logic model_start(input int inst);
        return reset && (rem[inst] == 0) && e_valid &&
               (e_class >= C_MULT) && (e_class <= C_DIVU) && !req;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d want=%0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Remaining busy cycles per instance; 0 means the MDU is free.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset)               rem[i] = 0;
            else if (model_start(i))  rem[i] = lat_of(i, e_class);
            else if (rem[i] > 0)      rem[i] = rem[i] - 1;
        end
    end

    task automatic check_inst(input int i);
        logic s, b, idle_ok;
        s       = model_start(i);
        b       = reset && ((rem[i] > 0) || s);
        idle_ok = reset && (rem[i] == 0) && e_valid && !req;
        check($sformatf("i%0d mdu_start", i), 32'(start_o[i]), 32'(s));
        check($sformatf("i%0d mdu_op", i), 32'(op_o[i]), s ? 32'(e_class) - 32'd1 : 32'd0);
        check($sformatf("i%0d hi_write", i), 32'(hiw_o[i]), 32'(idle_ok && e_class == C_MTHI));
        check($sformatf("i%0d lo_write", i), 32'(low_o[i]), 32'(idle_ok && e_class == C_MTLO));
        check($sformatf("i%0d hi_read", i), 32'(hir_o[i]), 32'(reset && e_valid && e_class == C_MFHI));
        check($sformatf("i%0d lo_read", i), 32'(lor_o[i]), 32'(reset && e_valid && e_class == C_MFLO));
        check($sformatf("i%0d busy", i), 32'(busy_o[i]), 32'(b));
        check($sformatf("i%0d stall_D", i), 32'(stall_o[i]), 32'(b && d_uses));
        check($sformatf("i%0d commit", i), 32'(commit_o[i]), 32'(reset && rem[i] == 1));
        check($sformatf("i%0d cnt", i), 32'(cnt_o[i]), reset ? 32'(rem[i]) : 32'd0);
        check($sformatf("i%0d state", i), 32'(dbg_o[i]), 32'(reset && rem[i] > 0));
    endtask

    task automatic drive(input logic rst, input logic v, input logic [3:0] cls,
                         input logic r, input logic d);
        @(negedge clk);
        reset   = rst;
        e_valid = v;
        e_class = cls;
        req     = r;
        d_uses  = d;
        #1;
        check_inst(0);
        check_inst(1);
    endtask

    task automatic flush();
        for (int k = 0; k < 18; k++) drive(1'b1, 1'b0, C_NONE, 1'b0, 1'b0);
    endtask

    initial begin
        int n_busy, n_stall, commit_at, n_commit;

        // Reset with junk inputs: all outputs must stay low.
        for (int k = 0; k < 3; k++)
            drive(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b1);
        check("reset cnt", 32'(cnt_o[0]), 32'd0);
        check("reset busy", 32'(busy_o[0]), 32'd0);
        flush();

        // MULT: start pulse, 6 busy cycles, cnt 5..0, commit in cycle 4.
        drive(1'b1, 1'b1, C_MULT, 1'b0, 1'b0);
        check("mult start", 32'(start_o[0]), 32'd1);
        check("mult op", 32'(op_o[0]), 32'd0);
        n_busy = busy_o[0] ? 1 : 0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 1'b0, C_NONE, 1'b0, 1'b0);
            check($sformatf("mult cnt c%0d", c), 32'(cnt_o[0]), 32'(5 - c));
            check($sformatf("mult commit c%0d", c), 32'(commit_o[0]), 32'(c == 4));
            if (busy_o[0]) n_busy++;
        end
        check("mult busy cycles", 32'(n_busy), 32'd6);
        flush();

        // DIVU with D_uses_mdu held high.
        drive(1'b1, 1'b1, C_DIVU, 1'b0, 1'b1);
        check("divu op", 32'(op_o[0]), 32'd3);
        n_stall = stall_o[0] ? 1 : 0;
        commit_at = -1;
        for (int c = 0; c < 12; c++) begin
            drive(1'b1, 1'b0, C_NONE, 1'b0, 1'b1);
            if (stall_o[0]) n_stall++;
            if (commit_o[0]) commit_at = c;
        end
        check("divu stall cycles", 32'(n_stall), 32'd11);
        check("divu commit cycle", 32'(commit_at), 32'd9);
        check("divu stall released", 32'(stall_o[0]), 32'd0);
        flush();

        // MTHI masked by Req, then accepted.
        drive(1'b1, 1'b1, C_MTHI, 1'b1, 1'b0);
        check("mthi req hi_write", 32'(hiw_o[0]), 32'd0);
        check("mthi req start", 32'(start_o[0]), 32'd0);
        drive(1'b1, 1'b1, C_MTHI, 1'b0, 1'b0);
        check("mthi hi_write", 32'(hiw_o[0]), 32'd1);
        drive(1'b1, 1'b1, C_MTLO, 1'b0, 1'b0);
        check("mtlo lo_write", 32'(low_o[0]), 32'd1);
        flush();

        // DIV running; Req asserted around cnt==4 must not disturb it.
        drive(1'b1, 1'b1, C_DIV, 1'b0, 1'b0);
        check("div op", 32'(op_o[0]), 32'd2);
        commit_at = -1;
        for (int c = 0; c < 11; c++) begin
            drive(1'b1, 1'b0, C_NONE, (c >= 6 && c <= 9), 1'b0);
            if (c == 6) check("div cnt at req", 32'(cnt_o[0]), 32'd4);
            if (commit_o[0]) commit_at = c;
        end
        check("div req commit cycle", 32'(commit_at), 32'd9);
        flush();

        // Reset while cnt==3 abandons the MULT.
        drive(1'b1, 1'b1, C_MULT, 1'b0, 1'b0);
        drive(1'b1, 1'b0, C_NONE, 1'b0, 1'b0);
        drive(1'b1, 1'b0, C_NONE, 1'b0, 1'b0);
        drive(1'b0, 1'b1, C_MULT, 1'b0, 1'b1);
        check("rst cnt", 32'(cnt_o[0]), 32'd0);
        check("rst stall", 32'(stall_o[0]), 32'd0);
        n_commit = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 1'b0, C_NONE, 1'b0, 1'b0);
            if (c == 0) check("rst cnt after", 32'(cnt_o[0]), 32'd0);
            if (commit_o[0]) n_commit++;
        end
        check("rst no commit", 32'(n_commit), 32'd0);
        flush();

        // MULTU injected during RUN is ignored.
        drive(1'b1, 1'b1, C_MULT, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, (c >= 1 && c <= 3), C_MULTU, 1'b0, 1'b0);
            if (c >= 1 && c <= 3) check($sformatf("viol start c%0d", c), 32'(start_o[0]), 32'd0);
            check($sformatf("viol cnt c%0d", c), 32'(cnt_o[0]), 32'(5 - c));
            check($sformatf("viol commit c%0d", c), 32'(commit_o[0]), 32'(c == 4));
        end
        flush();

        // Randomized traffic, including unused classes and occasional reset.
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
